// File: rtl/key_event_queue.sv
// Key event queue: scans the debounced key vector one key per cycle,
// turns each press/release it finds into an event and buffers the events
// in a small FIFO for the host-interface logic.
//
// Event handshake: evt_valid_o is high whenever at least one event is queued,
// and evt_key_o/evt_press_o then describe the oldest event. The event is
// consumed on a rising clk_i edge where evt_valid_o && evt_ready_i. While
// evt_valid_o is high and evt_ready_i is low, the head event is held
// unchanged. evt_valid_o never depends combinationally on evt_ready_i.
module key_event_queue #(
    parameter  int KEYS  = 61,
    parameter  int DEPTH = 16,
    localparam int IDX_W = $clog2(KEYS),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [KEYS-1:0]  keys_i,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [IDX_W-1:0] evt_key_o,
    output logic             evt_press_o,
    output logic [CNT_W-1:0] evt_count_o,
    output logic             scan_stall_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int EVT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEYS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // INIT captures the key vector once so keys held through reset stay silent.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    state_e           state_q;
    state_e           state_d;

    logic [KEYS-1:0]  prev_q;
    logic [IDX_W-1:0] idx_q;

    logic [EVT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic             cur_key;
    logic             mismatch;
    logic             fifo_full;
    logic             fifo_empty;
    logic             snap;
    logic             push;
    logic             pop;
    logic             advance;
    logic             stall;
    logic [EVT_W-1:0] head;

    // Key under the scanner and FIFO status, all from current registered state.
    always_comb begin
        cur_key    = keys_i[idx_q];
        mismatch   = (cur_key != prev_q[idx_q]);
        fifo_full  = (count_q == FULL_CNT);
        fifo_empty = (count_q == '0);
        pop        = !fifo_empty && evt_ready_i;
    end

    // Scanner control: snapshot in INIT, then push / skip / stall per key in SCAN.
    always_comb begin
        state_d = state_q;
        snap    = 1'b0;
        push    = 1'b0;
        advance = 1'b0;
        stall   = 1'b0;
        case (state_q)
            ST_INIT: begin
                snap    = 1'b1;
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (!mismatch) begin
                    advance = 1'b1;
                end else if (fifo_full) begin
                    // Full is judged on the current count only; a pop this
                    // cycle does not make room until next cycle.
                    stall = 1'b1;
                end else begin
                    push    = 1'b1;
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Snapshot of the last reported key states and the round-robin scan index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= '0;
            idx_q  <= '0;
        end else begin
            if (snap) begin
                prev_q <= keys_i;
            end else if (push) begin
                prev_q[idx_q] <= cur_key;
            end
            if (advance) begin
                idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end
        end
    end

    // Event storage; contents are only observed through valid entries.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {idx_q, cur_key};
        end
    end

    // FIFO pointers (wrap naturally) and exact occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Head event outputs, forced to zero while the queue is empty.
    always_comb begin
        head         = mem_q[rd_ptr_q];
        evt_valid_o  = !fifo_empty;
        evt_key_o    = fifo_empty ? '0 : head[EVT_W-1:1];
        evt_press_o  = !fifo_empty && head[0];
        evt_count_o  = count_q;
        scan_stall_o = stall;
    end

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed scenarios plus a randomized phase,
// with a reference model of the scanner and an event scoreboard.
module tb_key_event_queue;

    localparam int KEYS  = 61;
    localparam int DEPTH = 4;
    localparam int IDX_W = $clog2(KEYS);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int EVT_W = IDX_W + 1;

    // ---------------- clock / reset ----------------
    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [KEYS-1:0]  keys  = '0;
    logic             ready = 1'b1;

    logic             evt_valid;
    logic [IDX_W-1:0] evt_key;
    logic             evt_press;
    logic [CNT_W-1:0] evt_count;
    logic             scan_stall;

    always #5 clk = ~clk;

    key_event_queue #(
        .KEYS  (KEYS),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .keys_i       (keys),
        .evt_valid_o  (evt_valid),
        .evt_ready_i  (ready),
        .evt_key_o    (evt_key),
        .evt_press_o  (evt_press),
        .evt_count_o  (evt_count),
        .scan_stall_o (scan_stall)
    );

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;

    logic [EVT_W-1:0] exp_q[$];
    int               pop_log[$];
    int               n_popped   = 0;
    int               last_key   = -1;
    int               last_press = -1;
    int               max_cnt    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Evaluated at the falling edge with the inputs that the next rising edge
    // will see: scanner position, last reported key states, queue occupancy.
    bit              m_init = 1'b1;
    logic [KEYS-1:0] m_prev = '0;
    int              m_pos  = 0;
    int              m_cnt  = 0;

    always @(negedge clk) begin
        bit mis;
        bit full;
        bit pop;
        if (!rst_n) begin
            check("rst_valid", int'(evt_valid), 0);
            check("rst_count", int'(evt_count), 0);
            check("rst_stall", int'(scan_stall), 0);
            check("rst_key", int'(evt_key), 0);
            check("rst_press", int'(evt_press), 0);
            exp_q.delete();
            m_init = 1'b1;
            m_cnt  = 0;
            m_pos  = 0;
        end else begin
            check("count", int'(evt_count), m_cnt);
            check("valid", int'(evt_valid), int'(m_cnt != 0));
            if (m_init) begin
                check("stall_init", int'(scan_stall), 0);
                m_prev = keys;
                m_init = 1'b0;
            end else begin
                mis  = (keys[m_pos] != m_prev[m_pos]);
                full = (m_cnt == DEPTH);
                pop  = (m_cnt > 0) && ready;
                check("stall", int'(scan_stall), int'(mis && full));
                if (mis && !full) begin
                    exp_q.push_back({IDX_W'(m_pos), keys[m_pos]});
                    m_prev[m_pos] = keys[m_pos];
                    m_cnt++;
                end
                if (!(mis && full)) begin
                    m_pos = (m_pos + 1) % KEYS;
                end
                if (pop) begin
                    m_cnt--;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit               hold_pending = 1'b0;
    logic [EVT_W-1:0] held_evt     = '0;

    always @(negedge clk) begin
        logic [EVT_W-1:0] got;
        logic [EVT_W-1:0] want;
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            got = {evt_key, evt_press};
            if (int'(evt_count) > max_cnt) max_cnt = int'(evt_count);
            if (hold_pending) begin
                check("held_valid", int'(evt_valid), 1);
                check("held_event", int'(got), int'(held_evt));
            end
            hold_pending = evt_valid && !ready;
            held_evt     = got;
            if (evt_valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_event: got key %0d press %0d, expected none at %0t",
                             evt_key, evt_press, $time);
                end else begin
                    want = exp_q.pop_front();
                    check("event", int'(got), int'(want));
                end
                n_popped++;
                pop_log.push_back(int'(evt_key));
                last_key   = int'(evt_key);
                last_press = int'(evt_press);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 2 time units after the rising edge.
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Align to the cycle in which key 0 is next examined.
    task automatic wait_pos0();
        int guard = 0;
        while (m_pos != 0 && guard < 4 * KEYS) begin
            cycles(1);
            guard++;
        end
        if (m_pos != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scan_align: position %0d expected 0 after %0d cycles", m_pos, guard);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int guard;
        bit stall_seen;
        int order[6];
        order = '{2, 7, 9, 20, 33, 40};

        // Keys held through reset must not generate events.
        keys[3]  = 1'b1;
        keys[10] = 1'b1;
        ready    = 1'b1;
        cycles(3);
        rst_n = 1'b1;
        base  = n_popped;
        cycles(3 * KEYS);
        check("init_no_events", n_popped - base, 0);
        check("init_count", int'(evt_count), 0);

        // Single press and release of key 5.
        base    = n_popped;
        keys[5] = 1'b1;
        cycles(62);
        check("press5_events", n_popped - base, 1);
        check("press5_key", last_key, 5);
        check("press5_dir", last_press, 1);
        base    = n_popped;
        keys[5] = 1'b0;
        cycles(62);
        check("release5_events", n_popped - base, 1);
        check("release5_key", last_key, 5);
        check("release5_dir", last_press, 0);

        // Backpressure: six presses into a four-deep queue.
        ready = 1'b0;
        wait_pos0();
        base = n_popped;
        foreach (order[i]) keys[order[i]] = 1'b1;
        stall_seen = 1'b0;
        guard      = 0;
        while (!stall_seen && guard < 2 * KEYS) begin
            cycles(1);
            stall_seen = scan_stall;
            guard++;
        end
        check("full_stall_seen", int'(stall_seen), 1);
        check("full_count", int'(evt_count), DEPTH);
        cycles(20);
        check("full_count_held", int'(evt_count), DEPTH);
        ready = 1'b1;
        cycles(2 * KEYS);
        check("burst_events", n_popped - base, 6);
        if (pop_log.size() >= base + 6) begin
            foreach (order[i]) check("burst_order", pop_log[base + i], order[i]);
        end

        // One-cycle glitch on key 50 while the scanner is at key 0.
        wait_pos0();
        base     = n_popped;
        keys[50] = 1'b1;
        cycles(1);
        keys[50] = 1'b0;
        cycles(2 * KEYS);
        check("glitch_no_event", n_popped - base, 0);

        // Three events queued under backpressure, then reset mid-operation.
        ready = 1'b0;
        wait_pos0();
        keys[12] = 1'b1;
        keys[13] = 1'b1;
        keys[14] = 1'b1;
        cycles(20);
        check("queued3_count", int'(evt_count), 3);
        cycles(20);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(evt_valid), 0);
        check("async_rst_count", int'(evt_count), 0);
        cycles(1);
        rst_n = 1'b1;
        ready = 1'b1;
        base  = n_popped;
        cycles(3 * KEYS);
        check("reinit_no_events", n_popped - base, 0);

        // Toggle the first and last keys across the scan wrap point.
        max_cnt = 0;
        base    = n_popped;
        repeat (6) begin
            keys[0]  = ~keys[0];
            keys[60] = ~keys[60];
            cycles(KEYS + 2);
        end
        check("toggle_events", n_popped - base, 12);
        check("toggle_peak_le2", int'(max_cnt <= 2), 1);

        // Randomized key activity and backpressure.
        repeat (60) begin
            int nflip;
            int hold;
            nflip = $urandom_range(1, 3);
            repeat (nflip) begin
                int k;
                k = $urandom_range(0, KEYS - 1);
                keys[k] = ~keys[k];
            end
            hold = $urandom_range(1, 80);
            repeat (hold) begin
                ready = ($urandom_range(0, 9) < 4);
                cycles(1);
            end
        end
        ready = 1'b1;
        cycles(3 * KEYS + 2 * DEPTH);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_count", int'(evt_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Sits directly downstream of the key debouncer.
- Consumes the debounced key vector and detects per-key press/release transitions by round-robin scanning.
- Queues each transition as an event (key index + direction) in a small FIFO.
- Presents events to the host-interface logic over a valid/ready handshake. No event is lost under backpressure; the scan stalls instead.

Parameters:
- KEYS, 61, number of key inputs (width of the debounced vector).
- DEPTH, 16, FIFO depth in events; power of two, ≥2.
- IDX_W, $clog2(KEYS), width of the key index field (derived, not overridden).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived).

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- keys_i  input  KEYS  debounced key states from the debouncer, 1 = pressed.
- evt_valid_o  output  1  head-of-queue event is valid.
- evt_ready_i  input  1  consumer accepts the event this cycle.
- evt_key_o  output  IDX_W  key index of the head event.
- evt_press_o  output  1  1 = press (0→1), 0 = release (1→0).
- evt_count_o  output  CNT_W  number of events currently queued.
- scan_stall_o  output  1  scanner is blocked on a full FIFO.

Behaviour:
- Reset is asynchronous and active-low on rst_ni; single clock clk_i. On assert:
  - FSM goes to INIT; snapshot register prev cleared; scan index idx = 0.
  - FIFO emptied.
  - evt_valid_o = 0, evt_key_o = 0, evt_press_o = 0, evt_count_o = 0, scan_stall_o = 0.
- INIT (one cycle after reset release): prev <= keys_i for the whole vector, no events generated, then → SCAN.
  - Keys already held at reset therefore produce no spurious press events.
- SCAN: one key examined per cycle at index idx.
  - keys_i[idx] == prev[idx]: no action; idx advances.
  - Mismatch and FIFO not full: push {idx, keys_i[idx]}; prev[idx] <= keys_i[idx]; idx advances.
  - Mismatch and FIFO full: no push; prev and idx hold; scan_stall_o = 1 that cycle. The pending transition is re-evaluated next cycle, so it is never dropped.
  - idx wraps from KEYS-1 to 0. A full pass takes KEYS cycles absent stalls.
- Transitions that reverse before the scanner reaches the key generate no event. Only the value sampled at scan time is compared.
- Worst-case detection latency: KEYS cycles from the keys_i change to push, plus 1 cycle to evt_valid_o.
- FIFO:
  - Registered output, no fall-through. A push into an empty FIFO gives evt_valid_o = 1 on the next cycle.
  - Pop occurs when evt_valid_o && evt_ready_i.
  - Full is evaluated on the current count only. When full, a same-cycle pop does not enable a push; the push retries next cycle.
  - Simultaneous push and pop when neither full nor empty leaves the count unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally.
- evt_count_o tracks occupancy exactly, range 0..DEPTH.
- While evt_valid_o = 1 and evt_ready_i = 0, evt_key_o and evt_press_o are held stable.
- Events leave in push order. Within one pass that is ascending key index.
- Reset mid-operation discards all queued events and the snapshot, and re-enters INIT.

Test Plan:
- Reset release with keys_i[3] = 1, [10] = 1 held, ready = 1 → zero events over 3×KEYS cycles; evt_count_o stays 0.
- After INIT, set keys_i[5] = 1, ready = 1 → exactly one event with key = 5, press = 1 within 62 cycles. Clearing keys_i[5] → one event with key = 5, press = 0.
- DEPTH = 4, ready = 0, set keys 2, 7, 9, 20, 33, 40 at once:
  - evt_count_o reaches 4 and scan_stall_o asserts at key 33.
  - Raise ready → six events in order 2, 7, 9, 20, 33, 40, all press = 1, none lost or duplicated.
- Pulse keys_i[50] high for 1 cycle while the scanner is at idx 0 → no event for key 50.
- With 3 events queued and ready = 0 → head event fields constant for 20 cycles. Then assert rst_ni = 0 for 1 cycle → evt_valid_o = 0 and evt_count_o = 0 immediately (async), and INIT re-runs with no events for currently held keys.
- Toggle key 0 and key 60 repeatedly with ready = 1 → alternating press/release events per key; scanner wrap 60→0 verified; evt_count_o never exceeds 2.
